// File: rtl/wb_master_bridge_pkg.sv
// Shared definitions for Wishbone bus initiators: FSM state encodings and
// default bus widths matching the 64 KB word-addressed memory slaves.
package wb_master_bridge_pkg;

  localparam int WB_DATA_WIDTH_DEF = 32;
  localparam int WB_ADDR_WIDTH_DEF = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ERR  = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/wb_master_bridge_if.sv
// Wishbone classic bus bundle. The master modport is the initiator side
// (drives address/data/strobe); the slave modport is the memory side.
interface wb_master_bridge_if
  import wb_master_bridge_pkg::*;
#(
  parameter int DATA_WIDTH    = WB_DATA_WIDTH_DEF,
  parameter int WB_ADDR_WIDTH = WB_ADDR_WIDTH_DEF
);

  logic [WB_ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0]    wb_dat_o;
  logic [DATA_WIDTH-1:0]    wb_dat_i;
  logic                     wb_we_o;
  logic                     wb_stb_o;
  logic                     wb_cyc_o;
  logic                     wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator. Each accepted core request becomes exactly one
// Wishbone cycle; the result comes back as a one-cycle response pulse carrying
// read data or an error flag (misaligned address or no ack within the timeout).
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH_DEF,
  parameter int WB_ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [WB_ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  wb_master_bridge_if.master       wb
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e    state;
  bridge_state_e    state_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             misaligned;
  logic             count_last;

  assign req_ready  = (state == IDLE) && rst_n;
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign count_last = (count == CNT_LAST);

  // Next-state decode; an ack on the last timeout cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = misaligned ? ERR : BUS;
        end
      end
      BUS: begin
        if (wb.wb_ack_i || count_last) begin
          state_nxt = IDLE;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus outputs, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      count       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !misaligned) begin
            wb.wb_adr_o <= req_addr[WB_ADDR_WIDTH+1:2];
            wb.wb_dat_o <= req_wdata;
            wb.wb_we_o  <= req_we;
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            count       <= '0;
          end
        end
        BUS: begin
          if (wb.wb_ack_i) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_rdata   <= wb.wb_we_o ? '0 : wb.wb_dat_i;
          end else if (count_last) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed testbench for wb_master_bridge: a registered-ack memory slave model
// with selectable ack behaviour, hand-computed expected values throughout.
module tb_wb_master_bridge;

  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int TMO = 8;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW+1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  wb_master_bridge_if #(.DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) wb ();

  wb_master_bridge #(
    .DATA_WIDTH    (DW),
    .WB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .wb       (wb)
  );

  int compare_count = 0;
  int fail_count    = 0;

  // 0 = normal registered ack, 1 = never ack, 2 = ack only in the last timeout cycle
  int          ack_mode  = 0;
  logic        do_preset = 1'b1;
  logic [31:0] mem [0:1023];
  logic        ack_q;
  int          stb_run;

  int          stb_high;
  logic        cyc_seen;
  logic [31:0] last_dat;
  logic        last_we;
  logic [31:0] last_adr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: combinational read data, registered ack, writes while strobed
  assign wb.wb_dat_i = mem[wb.wb_adr_o[9:0]];
  assign wb.wb_ack_i = ack_q;

  always @(posedge clk) begin
    if (do_preset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hAAAA_AAAA;
    end else if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_we_o) begin
      mem[wb.wb_adr_o[9:0]] <= wb.wb_dat_o;
    end
    stb_run <= wb.wb_stb_o ? stb_run + 1 : 0;
    case (ack_mode)
      0:       ack_q <= wb.wb_cyc_o && wb.wb_stb_o && !ack_q;
      2:       ack_q <= wb.wb_cyc_o && wb.wb_stb_o && (stb_run == TMO - 2);
      default: ack_q <= 1'b0;
    endcase
  end

  // Bus monitor sampled mid-cycle
  always @(negedge clk) begin
    if (wb.wb_stb_o) begin
      stb_high = stb_high + 1;
      last_dat = wb.wb_dat_o;
      last_we  = wb.wb_we_o;
      last_adr = 32'(wb.wb_adr_o);
    end
    if (wb.wb_cyc_o) cyc_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present a request (called just after a negedge) and hold it until accepted
  task automatic applyStimulus(input logic we, input logic [AW+1:0] addr,
                               input logic [DW-1:0] wdata);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response pulse; lat counts cycles after the acceptance edge
  task automatic waitResponse(input int budget, output int lat, output logic [31:0] rdata,
                              output logic err, output logic ready, output logic cyc);
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    ready = 1'b0;
    cyc   = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat   = n;
        rdata = rsp_rdata;
        err   = rsp_err;
        ready = req_ready;
        cyc   = wb.wb_cyc_o;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    logic        cy;
    int          rsp_seen;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    stb_high  = 0;
    cyc_seen  = 1'b0;
    last_dat  = '0;
    last_we   = 1'b0;
    last_adr  = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cyc",       32'(wb.wb_cyc_o), 32'd0);
    checkOutput("rst_stb",       32'(wb.wb_stb_o), 32'd0);
    checkOutput("rst_we",        32'(wb.wb_we_o),  32'd0);
    checkOutput("rst_adr",       32'(wb.wb_adr_o), 32'd0);
    checkOutput("rst_dat",       wb.wb_dat_o,      32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid),   32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata,        32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err),     32'd0);
    checkOutput("rst_req_ready", 32'(req_ready),   32'd0);
    do_preset = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

    $display("[TB] read 0x10 from preset memory");
    applyStimulus(1'b0, 16'h0010, '0);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("rd10_adr",   last_adr,    32'd4);
    checkOutput("rd10_we",    32'(last_we), 32'd0);
    checkOutput("rd10_lat",   32'(lat),    32'd3);
    checkOutput("rd10_data",  rd,          32'hAAAA_AAAA);
    checkOutput("rd10_err",   32'(er),     32'd0);
    checkOutput("rd10_ready", 32'(rdy),    32'd1);

    $display("[TB] write 0xDEADBEEF to 0x100 then read back");
    applyStimulus(1'b1, 16'h0100, 32'hDEAD_BEEF);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("wr100_adr",   last_adr,     32'h40);
    checkOutput("wr100_we",    32'(last_we), 32'd1);
    checkOutput("wr100_dat",   last_dat,     32'hDEAD_BEEF);
    checkOutput("wr100_lat",   32'(lat),     32'd3);
    checkOutput("wr100_rdata", rd,           32'd0);
    checkOutput("wr100_err",   32'(er),      32'd0);
    checkOutput("wr100_gap",   32'(cy),      32'd0);
    applyStimulus(1'b0, 16'h0100, '0);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("rd100_lat",  32'(lat), 32'd3);
    checkOutput("rd100_data", rd,       32'hDEAD_BEEF);
    checkOutput("rd100_err",  32'(er),  32'd0);

    $display("[TB] misaligned read at 0x102");
    cyc_seen = 1'b0;
    applyStimulus(1'b0, 16'h0102, '0);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("mis_lat",   32'(lat),      32'd2);
    checkOutput("mis_err",   32'(er),       32'd1);
    checkOutput("mis_rdata", rd,            32'd0);
    checkOutput("mis_nocyc", 32'(cyc_seen), 32'd0);

    $display("[TB] slave never acks");
    ack_mode = 1;
    stb_high = 0;
    applyStimulus(1'b0, 16'h0200, '0);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("tmo_lat",      32'(lat),      32'd9);
    checkOutput("tmo_stb_high", 32'(stb_high), 32'd8);
    checkOutput("tmo_err",      32'(er),       32'd1);
    checkOutput("tmo_rdata",    rd,            32'd0);
    checkOutput("tmo_ready",    32'(rdy),      32'd1);

    $display("[TB] ack on the final timeout cycle");
    ack_mode = 0;
    applyStimulus(1'b1, 16'h0300, 32'h1234_5678);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("wr300_err", 32'(er), 32'd0);
    ack_mode = 2;
    applyStimulus(1'b0, 16'h0300, '0);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("late_lat",  32'(lat), 32'd9);
    checkOutput("late_err",  32'(er),  32'd0);
    checkOutput("late_data", rd,       32'h1234_5678);
    ack_mode = 0;

    $display("[TB] reset asserted mid-cycle");
    applyStimulus(1'b0, 16'h0010, '0);
    @(negedge clk);
    checkOutput("mid_stb_active", 32'(wb.wb_stb_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cyc",   32'(wb.wb_cyc_o), 32'd0);
    checkOutput("mid_rst_stb",   32'(wb.wb_stb_o), 32'd0);
    checkOutput("mid_rst_valid", 32'(rsp_valid),   32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready),   32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    checkOutput("mid_rst_no_rsp", 32'(rsp_seen), 32'd0);
    applyStimulus(1'b0, 16'h0010, '0);
    waitResponse(40, lat, rd, er, rdy, cy);
    checkOutput("post_rst_lat",  32'(lat), 32'd3);
    checkOutput("post_rst_data", rd,       32'hAAAA_AAAA);
    checkOutput("post_rst_err",  32'(er),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
